// File: rtl/daisi_ascii_pkg.sv
// Shared ASCII constants and sequencer state encoding.
// Used by hex_report_sequencer and nibble_to_ascii. Intended for reuse by a future ASCII receive/parse path.
package daisi_ascii_pkg;

    localparam logic [7:0] ASC_0  = 8'h30;
    localparam logic [7:0] ASC_A  = 8'h41;
    localparam logic [7:0] ASC_x  = 8'h78;
    localparam logic [7:0] ASC_CR = 8'h0D;
    localparam logic [7:0] ASC_LF = 8'h0A;

    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] ST_PFX0  = 3'd1;
    localparam logic [STATE_W-1:0] ST_PFX1  = 3'd2;
    localparam logic [STATE_W-1:0] ST_DIGIT = 3'd3;
    localparam logic [STATE_W-1:0] ST_CR    = 3'd4;
    localparam logic [STATE_W-1:0] ST_LF    = 3'd5;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE  = ST_IDLE,
        S_PFX0  = ST_PFX0,
        S_PFX1  = ST_PFX1,
        S_DIGIT = ST_DIGIT,
        S_CR    = ST_CR,
        S_LF    = ST_LF
    } seq_state_t;

endpackage

// File: rtl/nibble_to_ascii.sv
// Combinational 4-bit nibble to uppercase ASCII hex character.
// Ports:
//   nibble   in  4  binary digit 0..15
//   ascii_c  out 8  '0'..'9' or 'A'..'F' (combinational)
module nibble_to_ascii
    import daisi_ascii_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] ascii_c
);

    always_comb begin
        if (nibble < 4'd10) begin
            ascii_c = ASC_0 + 8'(nibble);
        end else begin
            ascii_c = ASC_A + 8'(nibble - 4'd10);
        end
    end

endmodule

// File: rtl/hex_report_sequencer.sv
// Serialises a captured value as an ASCII hex report line (MSB nibble first, uppercase, optional CR LF) onto a valid/ready byte stream for a UART transmitter.
// Optional "0x" prefix: define HEX_PREFIX_EN to build the PFX0/PFX1 states.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   value_in      value to report, latched on accept
//   value_valid   source has a value
//   value_ready   combinational, high only in IDLE
//   tx_data       registered ASCII byte
//   tx_valid      registered byte valid
//   tx_ready      UART consumed the byte this cycle
//   busy          registered, high outside IDLE
module hex_report_sequencer
    import daisi_ascii_pkg::*;
#(
    parameter int unsigned NUM_NIBBLES = 8,
    parameter bit          TERM_CRLF   = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [4*NUM_NIBBLES-1:0] value_in,
    input  logic                     value_valid,
    output logic                     value_ready,
    output logic [7:0]               tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic                     busy
);

    localparam int unsigned VAL_W = 4 * NUM_NIBBLES;
    localparam int unsigned IDX_W = (NUM_NIBBLES > 1) ? $clog2(NUM_NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NIBBLES - 1);

    seq_state_t       state, state_nx;
    logic [IDX_W-1:0] idx, idx_nx;
    logic [VAL_W-1:0] shadow, shadow_nx;
    logic [7:0]       tx_data_nx;
    logic             tx_valid_nx;

    logic [VAL_W-1:0] nib_src;
    logic [IDX_W-1:0] nib_sel;
    logic [3:0]       nib;
    logic [7:0]       digit_ascii;
    logic             hs;

    // Nibble mux selects the digit to be emitted next: MSB of value_in on accept, otherwise the shadow nibble following the current one.
    always_comb begin
        nib_src = (state == S_IDLE) ? value_in : shadow;
        nib_sel = ((state == S_DIGIT) && (idx != '0)) ? (idx - IDX_W'(1)) : LAST_IDX;
        nib     = 4'(nib_src >> {nib_sel, 2'b00});
    end

    nibble_to_ascii u_n2a (
        .nibble  (nib),
        .ascii_c (digit_ascii)
    );

    assign value_ready = (state == S_IDLE);
    assign hs          = tx_valid & tx_ready;

    // Next-state and next-output logic; everything holds unless a handshake advances it.
    always_comb begin
        state_nx    = state;
        idx_nx      = idx;
        shadow_nx   = shadow;
        tx_data_nx  = tx_data;
        tx_valid_nx = tx_valid;

        unique case (state)
            S_IDLE: begin
                if (value_valid) begin
                    shadow_nx   = value_in;
                    idx_nx      = LAST_IDX;
                    tx_valid_nx = 1'b1;
`ifdef HEX_PREFIX_EN
                    state_nx    = S_PFX0;
                    tx_data_nx  = ASC_0;
`else
                    state_nx    = S_DIGIT;
                    tx_data_nx  = digit_ascii;
`endif
                end
            end
`ifdef HEX_PREFIX_EN
            S_PFX0: begin
                if (hs) begin
                    state_nx   = S_PFX1;
                    tx_data_nx = ASC_x;
                end
            end
            S_PFX1: begin
                if (hs) begin
                    state_nx   = S_DIGIT;
                    tx_data_nx = digit_ascii;
                end
            end
`endif
            S_DIGIT: begin
                if (hs) begin
                    if (idx != '0) begin
                        idx_nx     = idx - IDX_W'(1);
                        tx_data_nx = digit_ascii;
                    end else if (TERM_CRLF) begin
                        state_nx   = S_CR;
                        tx_data_nx = ASC_CR;
                    end else begin
                        state_nx    = S_IDLE;
                        tx_valid_nx = 1'b0;
                    end
                end
            end
            S_CR: begin
                if (hs) begin
                    state_nx   = S_LF;
                    tx_data_nx = ASC_LF;
                end
            end
            S_LF: begin
                if (hs) begin
                    state_nx    = S_IDLE;
                    tx_valid_nx = 1'b0;
                end
            end
            default: begin
                state_nx    = S_IDLE;
                tx_valid_nx = 1'b0;
            end
        endcase
    end

    // State, shadow and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            idx      <= LAST_IDX;
            shadow   <= '0;
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nx;
            idx      <= idx_nx;
            shadow   <= shadow_nx;
            tx_data  <= tx_data_nx;
            tx_valid <= tx_valid_nx;
            busy     <= (state_nx != S_IDLE);
        end
    end

endmodule
